// File: rtl/calc_pkg.sv
// Shared encodings for the calculator datapath; the entry sequencer and the
// retain decoder both import this so their views of the state word agree.
package calc_pkg;

    localparam int CALC_DATA_W = 16;
    localparam int CALC_OP_W   = 2;

    typedef enum logic [2:0] {
        WAIT_A  = 3'b000,
        WAIT_B  = 3'b001,
        WAIT_OP = 3'b010,
        SHOW    = 3'b011
    } entry_state_t;

endpackage

// File: rtl/button_conditioner.sv
// Synchronises and debounces one raw pushbutton; emits a 1-cycle press pulse.
// Latency: level held from edge k gives the pulse after edge k+DEBOUNCE_CYCLES+2; no backpressure.
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic resetN,
    input  logic btn_raw,
    output logic press_pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q;
    logic             sync2_q;
    logic             stable_q;
    logic             stable_prev_q;
    logic             pulse_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
            pulse_q       <= 1'b0;
            cnt_q         <= '0;
        end else begin
            sync1_q       <= btn_raw;
            sync2_q       <= sync1_q;
            stable_prev_q <= stable_q;
            pulse_q       <= stable_q & ~stable_prev_q;
            // Any sample agreeing with the accepted level restarts the window.
            if (sync2_q == stable_q) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_LAST) begin
                stable_q <= sync2_q;
                cnt_q    <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign press_pulse = pulse_q;

endmodule

// File: rtl/entry_sequencer.sv
// Operand/operation entry FSM: A -> B -> OP -> SHOW on debounced ENTER, CLEAR wipes the entry.
// Latency: capture and state change on the edge a press pulse is seen; no backpressure.
module entry_sequencer
    import calc_pkg::*;
#(
    parameter int DATA_W          = CALC_DATA_W,
    parameter int OP_W            = CALC_OP_W,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              btn_enter,
    input  logic              btn_clear,
    input  logic [DATA_W-1:0] sw,
    output logic [2:0]        state,
    output logic [DATA_W-1:0] a_val,
    output logic [DATA_W-1:0] b_val,
    output logic [OP_W-1:0]   op_val,
    output logic              result_valid
);

    logic enter_pulse;
    logic clear_pulse;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter_btn (
        .clk         (clk),
        .resetN      (resetN),
        .btn_raw     (btn_enter),
        .press_pulse (enter_pulse)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_btn (
        .clk         (clk),
        .resetN      (resetN),
        .btn_raw     (btn_clear),
        .press_pulse (clear_pulse)
    );

    entry_state_t      state_q, state_d;
    logic [2:0]        state_cur;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [OP_W-1:0]   op_q, op_d;
    logic              rv_q, rv_d;

    assign state_cur = state_q;

    always_ff @(posedge clk) begin
        if (!resetN) begin
            state_q <= WAIT_A;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= '0;
            rv_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            rv_q    <= rv_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        if (clear_pulse) begin
            state_d = WAIT_A;
            a_d     = '0;
            b_d     = '0;
            op_d    = '0;
        end else if (state_cur[2]) begin
            // Unreachable encodings recover to the start without touching data.
            state_d = WAIT_A;
        end else if (enter_pulse) begin
            case (state_cur)
                WAIT_A: begin
                    a_d     = sw;
                    state_d = WAIT_B;
                end
                WAIT_B: begin
                    b_d     = sw;
                    state_d = WAIT_OP;
                end
                WAIT_OP: begin
                    op_d    = sw[OP_W-1:0];
                    state_d = SHOW;
                end
                default: state_d = WAIT_A;
            endcase
        end
        rv_d = (state_d == SHOW);
    end

    assign state        = state_q;
    assign a_val        = a_q;
    assign b_val        = b_q;
    assign op_val       = op_q;
    assign result_valid = rv_q;

endmodule

// File: tb/tb_entry_sequencer.sv
// Bench for entry_sequencer with a short debounce window and a sample-window reference model.
module tb_entry_sequencer;

    localparam int D = 4;

    logic        clk;
    logic        resetN;
    logic        btn_enter;
    logic        btn_clear;
    logic [15:0] sw;
    logic [2:0]  state;
    logic [15:0] a_val;
    logic [15:0] b_val;
    logic [1:0]  op_val;
    logic        result_valid;

    int checks = 0;
    int errors = 0;

    entry_sequencer #(.DATA_W(16), .OP_W(2), .DEBOUNCE_CYCLES(D)) dut (
        .clk          (clk),
        .resetN       (resetN),
        .btn_enter    (btn_enter),
        .btn_clear    (btn_clear),
        .sw           (sw),
        .state        (state),
        .a_val        (a_val),
        .b_val        (b_val),
        .op_val       (op_val),
        .result_valid (result_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: a level is accepted once D consecutive samples
    // (seen two edges late through the synchroniser) disagree with it;
    // a rising acceptance acts on the FSM two edges later.
    bit          eh[D+2];
    bit          ch[D+2];
    bit          est, cst;
    bit [1:0]    edly, cdly;
    bit          illegal_flag = 1'b0;
    logic [2:0]  m_state;
    logic [15:0] m_a, m_b;
    logic [1:0]  m_op;

    always @(posedge clk) begin
        bit en_act, cl_act, flip;
        if (!resetN) begin
            for (int i = 0; i < D + 2; i++) begin
                eh[i] = 1'b0;
                ch[i] = 1'b0;
            end
            est = 0; cst = 0; edly = 0; cdly = 0;
            m_state = 3'd0; m_a = 16'd0; m_b = 16'd0; m_op = 2'd0;
        end else begin
            en_act = edly[1];
            cl_act = cdly[1];
            if (cl_act) begin
                m_state = 3'd0; m_a = 16'd0; m_b = 16'd0; m_op = 2'd0;
            end else if (illegal_flag) begin
                m_state = 3'd0;
            end else if (en_act) begin
                if (m_state == 3'd0) m_a = sw;
                if (m_state == 3'd1) m_b = sw;
                if (m_state == 3'd2) m_op = sw[1:0];
                m_state = (m_state == 3'd3) ? 3'd0 : m_state + 3'd1;
            end
            edly[1] = edly[0];
            cdly[1] = cdly[0];
            for (int i = D + 1; i > 0; i--) begin
                eh[i] = eh[i-1];
                ch[i] = ch[i-1];
            end
            eh[0] = btn_enter;
            ch[0] = btn_clear;
            flip = 1'b1;
            for (int i = 2; i <= D + 1; i++) if (eh[i] == est) flip = 1'b0;
            edly[0] = flip & ~est;
            if (flip) est = ~est;
            flip = 1'b1;
            for (int i = 2; i <= D + 1; i++) if (ch[i] == cst) flip = 1'b0;
            cdly[0] = flip & ~cst;
            if (flip) cst = ~cst;
        end
    end

    task automatic do_reset();
        resetN = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0;
        repeat (3) @(negedge clk);
        resetN = 1'b1;
    endtask

    task automatic press(input logic en, input logic cl, input logic [15:0] v);
        sw = v; btn_enter = en; btn_clear = cl;
        repeat (D + 6) @(negedge clk);
        btn_enter = 1'b0; btn_clear = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic test_reset();
        logic [2:0] prev;
        int nadv = 0, adv_at = 0;
        resetN = 1'b0; btn_enter = 1'b1; btn_clear = 1'b0; sw = 16'h00AA;
        repeat (3) @(negedge clk);
        checks += 5;
        if (state !== 3'b000) begin errors++; $display("FAIL reset_state: got %b expected 000", state); end
        if (a_val !== 16'h0) begin errors++; $display("FAIL reset_a: got %h expected 0000", a_val); end
        if (b_val !== 16'h0) begin errors++; $display("FAIL reset_b: got %h expected 0000", b_val); end
        if (op_val !== 2'b00) begin errors++; $display("FAIL reset_op: got %b expected 00", op_val); end
        if (result_valid !== 1'b0) begin errors++; $display("FAIL reset_rv: got %b expected 0", result_valid); end
        resetN = 1'b1;
        prev = state;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (state !== prev) begin nadv++; adv_at = i; end
            prev = state;
        end
        checks += 4;
        if (nadv != 1) begin errors++; $display("FAIL reset_adv_count: got %0d expected 1", nadv); end
        if (adv_at != D + 4) begin errors++; $display("FAIL reset_adv_edge: got %0d expected %0d", adv_at, D + 4); end
        if (state !== 3'b001) begin errors++; $display("FAIL reset_adv_state: got %b expected 001", state); end
        if (a_val !== 16'h00AA) begin errors++; $display("FAIL reset_adv_a: got %h expected 00aa", a_val); end
        btn_enter = 1'b0;
        repeat (D + 6) @(negedge clk);
    endtask

    task automatic test_full_entry();
        do_reset();
        press(1'b1, 1'b0, 16'h0012);
        checks += 2;
        if (state !== 3'b001) begin errors++; $display("FAIL entry_s1: got %b expected 001", state); end
        if (a_val !== 16'h0012) begin errors++; $display("FAIL entry_a: got %h expected 0012", a_val); end
        press(1'b1, 1'b0, 16'h0034);
        checks += 2;
        if (state !== 3'b010) begin errors++; $display("FAIL entry_s2: got %b expected 010", state); end
        if (b_val !== 16'h0034) begin errors++; $display("FAIL entry_b: got %h expected 0034", b_val); end
        press(1'b1, 1'b0, 16'h0003);
        checks += 3;
        if (state !== 3'b011) begin errors++; $display("FAIL entry_s3: got %b expected 011", state); end
        if (op_val !== 2'b11) begin errors++; $display("FAIL entry_op: got %b expected 11", op_val); end
        if (result_valid !== 1'b1) begin errors++; $display("FAIL entry_rv: got %b expected 1", result_valid); end
        press(1'b1, 1'b0, 16'h0055);
        checks += 5;
        if (state !== 3'b000) begin errors++; $display("FAIL entry_wrap: got %b expected 000", state); end
        if (a_val !== 16'h0012) begin errors++; $display("FAIL entry_hold_a: got %h expected 0012", a_val); end
        if (b_val !== 16'h0034) begin errors++; $display("FAIL entry_hold_b: got %h expected 0034", b_val); end
        if (op_val !== 2'b11) begin errors++; $display("FAIL entry_hold_op: got %b expected 11", op_val); end
        if (result_valid !== 1'b0) begin errors++; $display("FAIL entry_wrap_rv: got %b expected 0", result_valid); end
    endtask

    task automatic test_bounce();
        logic [2:0] prev;
        int nadv = 0, adv_at = 0;
        sw = 16'h0077;
        for (int i = 0; i < 20; i++) begin
            btn_enter = ((i / 2) % 2 == 0);
            @(negedge clk);
            checks++;
            if (state !== 3'b000) begin errors++; $display("FAIL bounce_early: cycle %0d got %b expected 000", i, state); end
        end
        btn_enter = 1'b1;
        prev = state;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (state !== prev) begin nadv++; adv_at = i; end
            prev = state;
        end
        checks += 3;
        if (nadv != 1) begin errors++; $display("FAIL bounce_count: got %0d expected 1", nadv); end
        if (adv_at != D + 4) begin errors++; $display("FAIL bounce_edge: got %0d expected %0d", adv_at, D + 4); end
        if (a_val !== 16'h0077) begin errors++; $display("FAIL bounce_a: got %h expected 0077", a_val); end
        btn_enter = 1'b0;
        repeat (D + 6) @(negedge clk);
        btn_enter = 1'b1;
        repeat (D - 1) @(negedge clk);
        btn_enter = 1'b0;
        repeat (15) @(negedge clk);
        checks += 2;
        if (state !== 3'b001) begin errors++; $display("FAIL glitch_state: got %b expected 001", state); end
        if (state !== m_state) begin errors++; $display("FAIL glitch_model: got %b model %b", state, m_state); end
    endtask

    task automatic test_clear();
        do_reset();
        press(1'b1, 1'b0, 16'h0012);
        press(1'b1, 1'b0, 16'h0034);
        checks++;
        if (state !== 3'b010) begin errors++; $display("FAIL clear_pre: got %b expected 010", state); end
        press(1'b0, 1'b1, 16'hFFFF);
        checks += 4;
        if (state !== 3'b000) begin errors++; $display("FAIL clear_state: got %b expected 000", state); end
        if (a_val !== 16'h0) begin errors++; $display("FAIL clear_a: got %h expected 0000", a_val); end
        if (b_val !== 16'h0) begin errors++; $display("FAIL clear_b: got %h expected 0000", b_val); end
        if (op_val !== 2'b00) begin errors++; $display("FAIL clear_op: got %b expected 00", op_val); end
    endtask

    task automatic test_simultaneous();
        int e_at = 0, c_at = 0;
        do_reset();
        press(1'b1, 1'b0, 16'h0012);
        sw = 16'h0099; btn_enter = 1'b1; btn_clear = 1'b1;
        for (int i = 1; i <= 12; i++) begin
            @(negedge clk);
            if (dut.u_enter_btn.press_pulse && e_at == 0) e_at = i;
            if (dut.u_clear_btn.press_pulse && c_at == 0) c_at = i;
        end
        btn_enter = 1'b0; btn_clear = 1'b0;
        repeat (D + 6) @(negedge clk);
        checks += 6;
        if (e_at != D + 3 || c_at != D + 3) begin errors++; $display("FAIL sim_pulses: enter %0d clear %0d expected both %0d", e_at, c_at, D + 3); end
        if (state !== 3'b000) begin errors++; $display("FAIL sim_state: got %b expected 000", state); end
        if (a_val !== 16'h0) begin errors++; $display("FAIL sim_a: got %h expected 0000", a_val); end
        if (b_val !== 16'h0) begin errors++; $display("FAIL sim_b: got %h expected 0000", b_val); end
        if (op_val !== 2'b00) begin errors++; $display("FAIL sim_op: got %b expected 00", op_val); end
        if (result_valid !== 1'b0) begin errors++; $display("FAIL sim_rv: got %b expected 0", result_valid); end
    endtask

    task automatic test_illegal();
        do_reset();
        press(1'b1, 1'b0, 16'h0012);
        press(1'b1, 1'b0, 16'h0034);
        press(1'b1, 1'b0, 16'h0002);
        checks++;
        if (state !== 3'b011) begin errors++; $display("FAIL illegal_pre: got %b expected 011", state); end
        force dut.state_cur = 3'b110;
        illegal_flag = 1'b1;
        @(posedge clk);
        #1;
        release dut.state_cur;
        illegal_flag = 1'b0;
        @(negedge clk);
        checks += 5;
        if (state !== 3'b000) begin errors++; $display("FAIL illegal_state: got %b expected 000", state); end
        if (a_val !== 16'h0012) begin errors++; $display("FAIL illegal_a: got %h expected 0012", a_val); end
        if (b_val !== 16'h0034) begin errors++; $display("FAIL illegal_b: got %h expected 0034", b_val); end
        if (op_val !== 2'b10) begin errors++; $display("FAIL illegal_op: got %b expected 10", op_val); end
        if (result_valid !== 1'b0) begin errors++; $display("FAIL illegal_rv: got %b expected 0", result_valid); end
    endtask

    task automatic test_random();
        int seg = 0;
        do_reset();
        for (int cyc = 0; cyc < 1500; cyc++) begin
            if (seg == 0) begin
                seg       = $urandom_range(1, 9);
                btn_enter = 1'($urandom_range(0, 1));
                btn_clear = ($urandom_range(0, 5) == 0);
                sw        = 16'($urandom);
            end
            seg--;
            @(negedge clk);
            checks += 5;
            if (state !== m_state) begin errors++; $display("FAIL rand_state: cycle %0d got %b model %b", cyc, state, m_state); end
            if (a_val !== m_a) begin errors++; $display("FAIL rand_a: cycle %0d got %h model %h", cyc, a_val, m_a); end
            if (b_val !== m_b) begin errors++; $display("FAIL rand_b: cycle %0d got %h model %h", cyc, b_val, m_b); end
            if (op_val !== m_op) begin errors++; $display("FAIL rand_op: cycle %0d got %b model %b", cyc, op_val, m_op); end
            if (result_valid !== (m_state == 3'd3)) begin errors++; $display("FAIL rand_rv: cycle %0d got %b model %b", cyc, result_valid, m_state == 3'd3); end
        end
    endtask

    initial begin
        resetN = 1'b0; btn_enter = 1'b0; btn_clear = 1'b0; sw = 16'h0;
        @(negedge clk);
        test_reset();
        test_full_entry();
        test_bounce();
        test_clear();
        test_simultaneous();
        test_illegal();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
